// File: rtl/noc_params.sv
// Shared NoC router parameters for the switch allocator.
// Holds the default port/VC geometry, the derived index widths, the
// port-name enum and a one-hot to index helper used when turning arbiter
// grants into select fields.
package noc_params;

  localparam int PORT_NUM     = 5;
  localparam int VC_NUM       = 2;
  localparam int BUFFER_DEPTH = 4;
  localparam int PORT_SIZE    = $clog2(PORT_NUM);
  localparam int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CREDIT_SIZE  = $clog2(BUFFER_DEPTH + 1);

  typedef enum logic [PORT_SIZE-1:0] {
    PORT_LOCAL = 0,
    PORT_NORTH = 1,
    PORT_EAST  = 2,
    PORT_SOUTH = 3,
    PORT_WEST  = 4
  } port_t;

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic int oh_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : request vector
//   upd      : advance the pointer past the current winner at the clock edge
//   grant    : one-hot grant, first requester at or after the pointer
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          hit;
  int            j;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!hit && req[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  // The pointer only moves when the owner says the grant was final, so a
  // stage-1 winner that loses downstream keeps its priority.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (upd && hit)
      ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
  end

endmodule

// File: rtl/credit_switch_allocator.sv
// Credit-based separable input-first switch allocator.
//   clk, rst          : clock, synchronous active-high reset
//   switch_request_i  : [port][vc] upstream VC has a flit ready
//   out_port_i        : [port][vc] requested output port
//   downstream_vc_i   : [port][vc] allocated downstream VC
//   credit_valid_i    : [out] one credit returned this cycle
//   credit_vc_i       : [out] downstream VC of the returned credit
//   valid_sel_o       : [in]  input port granted this cycle
//   vc_sel_o          : [in]  granted VC of that input
//   input_vc_sel_o    : [out] crossbar select (input driving the output)
//   valid_flit_o      : [out] output carries a flit this cycle
//   credit_error_o    : sticky credit overflow / bad credit VC
// Grants are combinational from the request; credits and arbiter pointers
// update at the clock edge.
module credit_switch_allocator #(
  parameter int PORT_NUM     = noc_params::PORT_NUM,
  parameter int VC_NUM       = noc_params::VC_NUM,
  parameter int BUFFER_DEPTH = noc_params::BUFFER_DEPTH,
  parameter int PORT_SIZE    = $clog2(PORT_NUM),
  parameter int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int CREDIT_SIZE  = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               switch_request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_i,
  input  logic [PORT_NUM-1:0]                           credit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]              credit_vc_i,
  output logic [PORT_NUM-1:0]                           valid_sel_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]              vc_sel_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]            input_vc_sel_o,
  output logic [PORT_NUM-1:0]                           valid_flit_o,
  output logic                                          credit_error_o
);

  import noc_params::oh_to_idx;

  localparam logic [CREDIT_SIZE-1:0] FULL = CREDIT_SIZE'(BUFFER_DEPTH);

  // credit[o][v]: free slots in downstream VC v behind output o
  logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_SIZE-1:0] credit;

  logic [PORT_NUM-1:0][VC_NUM-1:0]    elig, inc, dec;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    s1_gnt;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   s1_idx, s1_dvc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] s1_out;
  logic [PORT_NUM-1:0]                s1_any;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req, s2_gnt;  // [out][in]
  int                                 win;

  // A VC is eligible only if its downstream VC has a credit now; a credit
  // arriving this cycle counts from the next cycle on.
  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        if (switch_request_i[p][v] && int'(out_port_i[p][v]) < PORT_NUM &&
            int'(downstream_vc_i[p][v]) < VC_NUM)
          elig[p][v] = credit[out_port_i[p][v]][downstream_vc_i[p][v]] != '0;
  end

  // Stage 1: one VC per input port.
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
    round_robin_arbiter #(.N(VC_NUM)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (elig[p]),
      .upd   (valid_sel_o[p]),
      .grant (s1_gnt[p])
    );
  end

  always_comb begin
    s1_idx = '0;
    s1_dvc = '0;
    s1_out = '0;
    s1_any = '0;
    s2_req = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      s1_idx[p] = VC_SIZE'(oh_to_idx(32'(s1_gnt[p])));
      s1_any[p] = |s1_gnt[p];
      s1_out[p] = out_port_i[p][s1_idx[p]];
      s1_dvc[p] = downstream_vc_i[p][s1_idx[p]];
    end
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        s2_req[o][p] = s1_any[p] && (int'(s1_out[p]) == o);
  end

  // Stage 2: one input per output port.
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    round_robin_arbiter #(.N(PORT_NUM)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (s2_req[o]),
      .upd   (valid_flit_o[o]),
      .grant (s2_gnt[o])
    );
  end

  // Each input targets a single output, so at most one stage-2 arbiter can
  // grant a given input and the per-input writes below never collide.
  always_comb begin
    valid_sel_o    = '0;
    vc_sel_o       = '0;
    input_vc_sel_o = '0;
    valid_flit_o   = '0;
    dec            = '0;
    win            = 0;
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (|s2_gnt[o]) begin
          win               = oh_to_idx(32'(s2_gnt[o]));
          valid_flit_o[o]   = 1'b1;
          input_vc_sel_o[o] = PORT_SIZE'(win);
          valid_sel_o[win]  = 1'b1;
          vc_sel_o[win]     = s1_idx[win];
          dec[o][s1_dvc[win]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    inc = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int v = 0; v < VC_NUM; v++)
        inc[o][v] = credit_valid_i[o] && (int'(credit_vc_i[o]) == v);
  end

  // Simultaneous return and send cancel; a return into a full counter
  // saturates and flags the upstream accounting error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++)
        for (int v = 0; v < VC_NUM; v++)
          credit[o][v] <= FULL;
      credit_error_o <= 1'b0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (credit_valid_i[o] && int'(credit_vc_i[o]) >= VC_NUM)
          credit_error_o <= 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
          if (inc[o][v] && !dec[o][v]) begin
            if (credit[o][v] == FULL)
              credit_error_o <= 1'b1;
            else
              credit[o][v] <= credit[o][v] + CREDIT_SIZE'(1);
          end else if (dec[o][v] && !inc[o][v]) begin
            credit[o][v] <= credit[o][v] - CREDIT_SIZE'(1);
          end
        end
      end
    end
  end

endmodule
